// File: rtl/wb_stage_pkg.sv
// Shared write-back encodings: WD-select and load-extension codes, opcode/funct constants,
// and the W-stage instruction decoder used for destination and data selection.
package wb_stage_pkg;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC8 = 2'd2;
    localparam logic [1:0] WD_MD  = 2'd3;

    localparam logic [2:0] EXT_LW  = 3'd0;
    localparam logic [2:0] EXT_LH  = 3'd1;
    localparam logic [2:0] EXT_LHU = 3'd2;
    localparam logic [2:0] EXT_LB  = 3'd3;
    localparam logic [2:0] EXT_LBU = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] wd_sel;
        logic [2:0] ext;
        logic       is_load;
    } wb_dec_t;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] md;
    } wb_regs_t;

    function automatic wb_dec_t wb_decode(input logic [31:0] ir);
        wb_dec_t    d;
        logic [4:0] rt;
        logic [4:0] rd;
        rt = ir[20:16];
        rd = ir[15:11];
        d  = '{a3: 5'd0, wd_sel: WD_ALU, ext: EXT_LW, is_load: 1'b0};
        case (ir[31:26])
            OP_RTYPE: begin
                case (ir[5:0])
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: d.a3 = rd;
                    FN_JALR: begin d.a3 = rd; d.wd_sel = WD_PC8; end
                    FN_MFHI, FN_MFLO: begin d.a3 = rd; d.wd_sel = WD_MD; end
                    default: ;  // jr, mult/div, mthi/mtlo: no RF write
                endcase
            end
            OP_JAL: begin d.a3 = 5'd31; d.wd_sel = WD_PC8; end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: d.a3 = rt;
            OP_LB:  begin d.a3 = rt; d.wd_sel = WD_MEM; d.ext = EXT_LB;  d.is_load = 1'b1; end
            OP_LBU: begin d.a3 = rt; d.wd_sel = WD_MEM; d.ext = EXT_LBU; d.is_load = 1'b1; end
            OP_LH:  begin d.a3 = rt; d.wd_sel = WD_MEM; d.ext = EXT_LH;  d.is_load = 1'b1; end
            OP_LHU: begin d.a3 = rt; d.wd_sel = WD_MEM; d.ext = EXT_LHU; d.is_load = 1'b1; end
            OP_LW:  begin d.a3 = rt; d.wd_sel = WD_MEM; d.ext = EXT_LW;  d.is_load = 1'b1; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load-data extension: picks the byte/half addressed by off out of the aligned word and
// sign- or zero-extends it.
import wb_stage_pkg::*;

module wb_load_ext (
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  ext,
    output logic [31:0] data
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half     = off[1] ? word[31:16] : word[15:0];
        byte_sel = word[8*off +: 8];
        case (ext)
            EXT_LH:  data = {{16{half[15]}}, half};
            EXT_LHU: data = {16'h0, half};
            EXT_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            EXT_LBU: data = {24'h0, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: M/W register, destination select, write-data mux and RF write enable.
// Define WB_ALIGN_CHK_EN to trap misaligned lw/lh/lhu and expose exc_AdEL_W.
import wb_stage_pkg::*;

module wb_stage #(
    parameter logic [31:0] RESET_PC4 = 32'h0000_3004,
    parameter logic [31:0] NOP_IR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_W,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC4_M,
    input  logic [31:0] ALUout_M,
    input  logic [31:0] DMrd_M,
    input  logic [31:0] MDout_M,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic        RegWrite_W,
    output logic [31:0] PC4_W,
    output logic [31:0] IR_W,
    output logic        valid_W
`ifdef WB_ALIGN_CHK_EN
    ,
    output logic        exc_AdEL_W
`endif
);

    wb_regs_t    w;
    logic        vld;
    wb_dec_t     dec;
    logic [31:0] ld_data;
    logic        wr_ok;

    always_ff @(posedge clk) begin
        if (reset || clr_W) begin
            w   <= '{ir: NOP_IR, pc4: RESET_PC4, alu: 32'h0, dm: 32'h0, md: 32'h0};
            vld <= 1'b0;
        end else begin
            w   <= '{ir: IR_M, pc4: PC4_M, alu: ALUout_M, dm: DMrd_M, md: MDout_M};
            vld <= 1'b1;
        end
    end

    assign dec = wb_decode(w.ir);

    wb_load_ext u_load_ext (
        .word (w.dm),
        .off  (w.alu[1:0]),
        .ext  (dec.ext),
        .data (ld_data)
    );

`ifdef WB_ALIGN_CHK_EN
    logic misalign;
    always_comb begin
        case (dec.ext)
            EXT_LW:          misalign = w.alu[1:0] != 2'b00;
            EXT_LH, EXT_LHU: misalign = w.alu[0];
            default:         misalign = 1'b0;
        endcase
    end
    assign exc_AdEL_W = vld && dec.is_load && misalign;
    assign wr_ok      = !exc_AdEL_W;
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        case (dec.wd_sel)
            WD_MEM:  WD = ld_data;
            WD_PC8:  WD = w.pc4 + 32'd4;
            WD_MD:   WD = w.md;
            default: WD = w.alu;
        endcase
    end

    assign A3         = dec.a3;
    assign RegWrite_W = vld && (dec.a3 != 5'd0) && wr_ok;
    assign PC4_W      = w.pc4;
    assign IR_W       = w.ir;
    assign valid_W    = vld;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset state, vector table through the M/W register,
// clear/reset sequences and the misaligned-load case.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset, clr_W;
    logic [31:0] IR_M, PC4_M, ALUout_M, DMrd_M, MDout_M;
    logic [4:0]  A3;
    logic [31:0] WD, PC4_W, IR_W;
    logic        RegWrite_W, valid_W;
`ifdef WB_ALIGN_CHK_EN
    logic        exc_AdEL_W;
`endif

    always #5 clk = ~clk;

    wb_stage dut (
        .clk        (clk),
        .reset      (reset),
        .clr_W      (clr_W),
        .IR_M       (IR_M),
        .PC4_M      (PC4_M),
        .ALUout_M   (ALUout_M),
        .DMrd_M     (DMrd_M),
        .MDout_M    (MDout_M),
        .A3         (A3),
        .WD         (WD),
        .RegWrite_W (RegWrite_W),
        .PC4_W      (PC4_W),
        .IR_W       (IR_W),
        .valid_W    (valid_W)
`ifdef WB_ALIGN_CHK_EN
        ,
        .exc_AdEL_W (exc_AdEL_W)
`endif
    );

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] md;
        logic        clr;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        rw;
        logic        vld;
    } vec_t;

    localparam int NV = 24;
    localparam logic [31:0] D = 32'h80FF_7F01;

    vec_t vec [NV];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc4, input logic [31:0] alu,
                         input logic [31:0] dm, input logic [31:0] md, input logic clr);
        IR_M = ir; PC4_M = pc4; ALUout_M = alu; DMrd_M = dm; MDout_M = md; clr_W = clr;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDU3 = 32'h0022_1821;  // addu $3,$1,$2

    initial begin
        vec[0]  = '{ADDU3,        32'h3008, 32'h5,        D, 32'hAAAA, 1'b0, 5'd3,  32'h5,        1'b1, 1'b1};
        vec[1]  = '{32'h8004_0000, 32'h300C, 32'h1003,    D, 32'h0,    1'b0, 5'd4,  32'hFFFF_FF80, 1'b1, 1'b1};
        vec[2]  = '{32'h9004_0000, 32'h3010, 32'h1003,    D, 32'h0,    1'b0, 5'd4,  32'h0000_0080, 1'b1, 1'b1};
        vec[3]  = '{32'h8404_0000, 32'h3014, 32'h1002,    D, 32'h0,    1'b0, 5'd4,  32'hFFFF_80FF, 1'b1, 1'b1};
        vec[4]  = '{32'h9404_0000, 32'h3018, 32'h1002,    D, 32'h0,    1'b0, 5'd4,  32'h0000_80FF, 1'b1, 1'b1};
        vec[5]  = '{32'h8404_0000, 32'h301C, 32'h1000,    D, 32'h0,    1'b0, 5'd4,  32'h0000_7F01, 1'b1, 1'b1};
        vec[6]  = '{32'h8004_0000, 32'h3020, 32'h1001,    D, 32'h0,    1'b0, 5'd4,  32'h0000_007F, 1'b1, 1'b1};
        vec[7]  = '{32'h8004_0000, 32'h3024, 32'h1002,    D, 32'h0,    1'b0, 5'd4,  32'hFFFF_FFFF, 1'b1, 1'b1};
        vec[8]  = '{32'h9004_0000, 32'h3028, 32'h1000,    D, 32'h0,    1'b0, 5'd4,  32'h0000_0001, 1'b1, 1'b1};
        vec[9]  = '{32'h8C04_0000, 32'h302C, 32'h1000,    D, 32'h0,    1'b0, 5'd4,  D,             1'b1, 1'b1};
        vec[10] = '{32'h0C00_0000, 32'h3010, 32'h1234,    D, 32'h0,    1'b0, 5'd31, 32'h3014,      1'b1, 1'b1};
        vec[11] = '{32'h00A0_0009, 32'h3020, 32'h0,       D, 32'h0,    1'b0, 5'd0,  32'h3024,      1'b0, 1'b1};
        vec[12] = '{32'h00A0_F809, 32'h3030, 32'h0,       D, 32'h0,    1'b0, 5'd31, 32'h3034,      1'b1, 1'b1};
        vec[13] = '{32'h0000_3810, 32'h3034, 32'h11,      D, 32'hDEAD_BEEF, 1'b0, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vec[14] = '{32'h0022_0018, 32'h3038, 32'h55,      D, 32'h0,    1'b0, 5'd0,  32'h55,        1'b0, 1'b1};
        vec[15] = '{32'h3425_00FF, 32'h303C, 32'hFF,      D, 32'h0,    1'b0, 5'd5,  32'hFF,        1'b1, 1'b1};
        vec[16] = '{32'h3C06_ABCD, 32'h3040, 32'hABCD_0000, D, 32'h0,  1'b0, 5'd6,  32'hABCD_0000, 1'b1, 1'b1};
        vec[17] = '{32'hAC04_0000, 32'h3044, 32'h1000,    D, 32'h0,    1'b0, 5'd0,  32'h1000,      1'b0, 1'b1};
        vec[18] = '{32'h1022_0000, 32'h3048, 32'h9,       D, 32'h0,    1'b0, 5'd0,  32'h9,         1'b0, 1'b1};
        vec[19] = '{32'hFC84_0000, 32'h304C, 32'h77,      D, 32'h0,    1'b0, 5'd0,  32'h77,        1'b0, 1'b1};
        vec[20] = '{32'h0000_0000, 32'h3050, 32'h0,       D, 32'h0,    1'b0, 5'd0,  32'h0,         1'b0, 1'b1};
        vec[21] = '{ADDU3,        32'h3054, 32'h99,       D, 32'h0,    1'b1, 5'd0,  32'h0,         1'b0, 1'b0};
        vec[22] = '{ADDU3,        32'h3058, 32'h42,       D, 32'h0,    1'b0, 5'd3,  32'h42,        1'b1, 1'b1};
        vec[23] = '{32'h3420_0003, 32'h305C, 32'h3,       D, 32'h0,    1'b0, 5'd0,  32'h3,         1'b0, 1'b1};

        // reset held two cycles with a live writer sitting in M
        reset = 1'b1; clr_W = 1'b0;
        IR_M = ADDU3; PC4_M = 32'h3100; ALUout_M = 32'h7; DMrd_M = D; MDout_M = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.IR_W",  IR_W,  32'h0);
        chk("rst.PC4_W", PC4_W, 32'h3004);
        chk("rst.rw",    {31'h0, RegWrite_W}, 32'h0);
        chk("rst.valid", {31'h0, valid_W},    32'h0);
        chk("rst.WD",    WD,    32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vec[i].ir, vec[i].pc4, vec[i].alu, vec[i].dm, vec[i].md, vec[i].clr);
            chk($sformatf("v%0d.A3", i),    {27'h0, A3},         {27'h0, vec[i].a3});
            chk($sformatf("v%0d.WD", i),    WD,                  vec[i].wd);
            chk($sformatf("v%0d.rw", i),    {31'h0, RegWrite_W}, {31'h0, vec[i].rw});
            chk($sformatf("v%0d.valid", i), {31'h0, valid_W},    {31'h0, vec[i].vld});
            chk($sformatf("v%0d.IR_W", i),  IR_W,  vec[i].clr ? 32'h0 : vec[i].ir);
            chk($sformatf("v%0d.PC4_W", i), PC4_W, vec[i].clr ? 32'h3004 : vec[i].pc4);
        end

        // reset and clear together mid-stream: reset wins, same bubble
        reset = 1'b1;
        drive(ADDU3, 32'h3200, 32'h8, D, 32'h0, 1'b1);
        chk("rstclr.valid", {31'h0, valid_W}, 32'h0);
        chk("rstclr.PC4_W", PC4_W, 32'h3004);
        reset = 1'b0;
        drive(ADDU3, 32'h3204, 32'h8, D, 32'h0, 1'b0);
        chk("post.rw", {31'h0, RegWrite_W}, 32'h1);
        chk("post.WD", WD, 32'h8);

        // misaligned lw at 0x1002 followed by an aligned one
        drive(32'h8C04_0000, 32'h3208, 32'h1002, D, 32'h0, 1'b0);
`ifdef WB_ALIGN_CHK_EN
        chk("mis.rw",  {31'h0, RegWrite_W}, 32'h0);
        chk("mis.exc", {31'h0, exc_AdEL_W}, 32'h1);
`else
        chk("mis.rw",  {31'h0, RegWrite_W}, 32'h1);
        chk("mis.WD",  WD, D);
`endif
        drive(32'h8404_0000, 32'h320C, 32'h1003, D, 32'h0, 1'b0);
`ifdef WB_ALIGN_CHK_EN
        chk("mislh.rw",  {31'h0, RegWrite_W}, 32'h0);
        chk("mislh.exc", {31'h0, exc_AdEL_W}, 32'h1);
`else
        chk("mislh.rw",  {31'h0, RegWrite_W}, 32'h1);
        chk("mislh.WD",  WD, 32'hFFFF_80FF);
`endif
        drive(32'h8C04_0000, 32'h3210, 32'h1004, D, 32'h0, 1'b0);
        chk("al.rw", {31'h0, RegWrite_W}, 32'h1);
        chk("al.WD", WD, D);
`ifdef WB_ALIGN_CHK_EN
        chk("al.exc", {31'h0, exc_AdEL_W}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
